// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: staged reset release for memory then CPU, gated on a
// stable PLL lock, with continuous lock supervision and a relock counter.
//
// Optional build macro: PLL_LOCK_TIMEOUT_EN
//   When defined, WAIT_LOCK gives up after TIMEOUT_CYCLES unlocked cycles,
//   raises a sticky lock_timeout flag and releases the resets anyway; lock
//   loss is ignored from then on. When undefined, WAIT_LOCK waits forever
//   and lock_timeout is tied low.
//
// Handshake note: this block has no valid/ready interfaces. pll_lock is a
// level that is synchronized into the clk domain; all outputs are registered.
module pll_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_DELAY        = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 65536,
    parameter int unsigned CNT_W              = 17
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    output logic       mem_resetn,
    output logic       cpu_resetn,
    output logic       sys_ready,
    output logic [7:0] relock_count,
    output logic       lock_timeout
);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL_MEM   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);

    // Elaboration-time sanity checks on the configuration.
    if (LOCK_STABLE_CYCLES < 1 || STAGE_DELAY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_min
        $error("pll_reset_sequencer: cycle parameters must be >= 1");
    end
    if (64'(LOCK_STABLE_CYCLES) > (64'd1 << CNT_W) || 64'(STAGE_DELAY) > (64'd1 << CNT_W) ||
        64'(TIMEOUT_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_width
        $error("pll_reset_sequencer: a cycle parameter exceeds the counter range");
    end

    // ---------------------------------------------------------------
    // Synchronizers
    // ---------------------------------------------------------------
    logic [1:0] rst_sync_q, rst_sync_d;
    logic [1:0] lock_sync_q, lock_sync_d;
    logic       rst_s_n;   // internal reset, low while asserted
    logic       lock_s;

    always_comb begin
        rst_sync_d  = {rst_sync_q[0], 1'b1};
        lock_sync_d = {lock_sync_q[0], pll_lock};
    end

    assign rst_s_n = rst_sync_q[1];
    assign lock_s  = lock_sync_q[1];

    // Reset synchronizer: asserts asynchronously, releases after two edges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_sync_q <= 2'b00;
        else         rst_sync_q <= rst_sync_d;
    end

    // Lock synchronizer, cleared by the raw board reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lock_sync_q <= 2'b00;
        else         lock_sync_q <= lock_sync_d;
    end

    // ---------------------------------------------------------------
    // Sequencer state
    // ---------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       relock_q, relock_d;
    logic             mem_q, mem_d;
    logic             cpu_q, cpu_d;
    logic             timeout_q, timeout_d;
    logic             loss_en;   // lock loss is acted on in REL_MEM/RUN

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    assign loss_en = !lock_s && !timeout_q;
`else
    assign loss_en = !lock_s;
`endif

    // Next-state, counter, relock counter and registered output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        relock_d  = relock_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_HOLD: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
`ifdef PLL_LOCK_TIMEOUT_EN
                    if (cnt_q == TIMEOUT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_REL_MEM;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_REL_MEM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REL_MEM: begin
                if (loss_en) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end else if (cnt_q == STAGE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (loss_en) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase
        // Outputs follow the state being entered, so they change on the same edge.
        mem_d = (state_d == ST_REL_MEM) || (state_d == ST_RUN);
        cpu_d = (state_d == ST_RUN);
    end

    // State, counter and output registers, cleared by the synchronized reset.
    always_ff @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            relock_q  <= 8'd0;
            mem_q     <= 1'b0;
            cpu_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            relock_q  <= relock_d;
            mem_q     <= mem_d;
            cpu_q     <= cpu_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_resetn   = mem_q;
    assign cpu_resetn   = cpu_q;
    assign sys_ready    = cpu_q;
    assign relock_count = relock_q;
`ifdef PLL_LOCK_TIMEOUT_EN
    assign lock_timeout = timeout_q;
`else
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer (LOCK_STABLE_CYCLES=8, STAGE_DELAY=4,
// TIMEOUT_CYCLES=32). Edge 0 is the first clk edge with resetn high.
module tb_pll_reset_sequencer;

    localparam int L = 8;
    localparam int S = 4;
    localparam int T = 32;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_lock = 1'b0;
    logic       mem_resetn, cpu_resetn, sys_ready, lock_timeout;
    logic [7:0] relock_count;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES(L),
        .STAGE_DELAY(S),
        .TIMEOUT_CYCLES(T),
        .CNT_W(17)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .pll_lock(pll_lock),
        .mem_resetn(mem_resetn),
        .cpu_resetn(cpu_resetn),
        .sys_ready(sys_ready),
        .relock_count(relock_count),
        .lock_timeout(lock_timeout)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // lock_s seen at edge n is pll_lock as sampled at edge n-2. The sequence
    // is described by the length of the current run of consecutive locked
    // samples: memory is out of reset once L+1 samples have been seen, the
    // CPU after S more.
    bit m_hist[$];
    int m_edge;
    int m_run;
    int m_wait0;
    bit m_to;
    int m_relock;

    task automatic model_reset();
        m_hist.delete();
        m_edge   = 0;
        m_run    = 0;
        m_wait0  = 0;
        m_to     = 1'b0;
        m_relock = 0;
    endtask

    task automatic model_edge(input bit lk);
        bit ls;
        int was;
        ls = (m_edge >= 2) ? m_hist[m_edge-2] : 1'b0;
        m_hist.push_back(lk);
        if (m_edge >= 3) begin
            if (m_to) begin
                m_run++;
            end else if (ls) begin
                m_run++;
                m_wait0 = 0;
            end else begin
                was   = m_run;
                m_run = 0;
                if (was >= L + 1 && m_relock < 255) m_relock++;
                if (was == 0) begin
`ifdef PLL_LOCK_TIMEOUT_EN
                    m_wait0++;
                    if (m_wait0 == T) begin
                        m_to  = 1'b1;
                        m_run = L + 1;
                    end
`endif
                end else begin
                    m_wait0 = 0;
                end
            end
        end
        m_edge++;
    endtask

    function automatic logic [11:0] model_vec();
        bit mem, cpu;
        mem = (m_run >= L + 1);
        cpu = (m_run >= L + 1 + S);
        return {mem, cpu, cpu, m_to, 8'(m_relock)};
    endfunction

    // ---------------- scoreboard ----------------
    function automatic logic [11:0] dut_vec();
        return {mem_resetn, cpu_resetn, sys_ready, lock_timeout, relock_count};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got{mem,cpu,rdy,to,relock}=%h expected=%h",
                     name, m_edge - 1, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit lk);
        pll_lock = lk;
        @(posedge clk);
        model_edge(lk);
        #1;
        check("model", dut_vec(), model_vec());
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn   = 1'b0;
        pll_lock = 1'b0;
        #1;
        check("reset_state", dut_vec(), 12'h000);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        int edge_n;
        bit mem;
        bit cpu;
    } vec_t;

    vec_t nom_tbl[6];
    vec_t unst_tbl[6];

    // Run n edges with pll_lock=1 except at drop_edge; compare table points.
    task automatic run_seq(input string name, input int n, input int drop_edge, input vec_t t[6]);
        for (int e = 0; e < n; e++) begin
            step(e != drop_edge);
            for (int i = 0; i < 6; i++) begin
                if (t[i].edge_n == e)
                    check(name, {mem_resetn, cpu_resetn, sys_ready},
                          {9'd0, t[i].mem, t[i].cpu, t[i].cpu});
            end
        end
    endtask

    // ---------------- test ----------------
    initial begin
        nom_tbl[0] = '{2, 1'b0, 1'b0};
        nom_tbl[1] = '{10, 1'b0, 1'b0};
        nom_tbl[2] = '{11, 1'b1, 1'b0};
        nom_tbl[3] = '{14, 1'b1, 1'b0};
        nom_tbl[4] = '{15, 1'b1, 1'b1};
        nom_tbl[5] = '{19, 1'b1, 1'b1};

        // pll_lock low at edge 7 is seen by STABLE at edge 9 with cnt=5.
        unst_tbl[0] = '{11, 1'b0, 1'b0};
        unst_tbl[1] = '{17, 1'b0, 1'b0};
        unst_tbl[2] = '{18, 1'b1, 1'b0};
        unst_tbl[3] = '{21, 1'b1, 1'b0};
        unst_tbl[4] = '{22, 1'b1, 1'b1};
        unst_tbl[5] = '{24, 1'b1, 1'b1};

        model_reset();

        // Nominal bring-up
        apply_reset();
        run_seq("nominal", 20, -1, nom_tbl);

        // Unstable lock during STABLE
        apply_reset();
        run_seq("unstable", 25, 7, unst_tbl);
        check("unstable_relock", {4'd0, relock_count}, 12'd0);

        // First lock loss in RUN
        step(1'b0);
        step(1'b1);
        check("loss_pre", {9'd0, mem_resetn, cpu_resetn, sys_ready}, 12'h007);
        step(1'b1);
        check("loss_drop", dut_vec(), 12'h001);
        for (int j = 1; j <= 16; j++) begin
            step(1'b1);
            if (j == 8)  check("relock_mem_early", {11'd0, mem_resetn}, 12'd0);
            if (j == 9)  check("relock_mem", {11'd0, mem_resetn}, 12'd1);
            if (j == 12) check("relock_cpu_early", {11'd0, cpu_resetn}, 12'd0);
            if (j == 13) check("relock_cpu", {10'd0, cpu_resetn, sys_ready}, 12'd3);
        end

        // Repeated lock loss: relock_count saturates
        for (int r = 0; r < 299; r++) begin
            step(1'b0);
            for (int j = 0; j < 17; j++) step(1'b1);
        end
        check("relock_sat", {4'd0, relock_count}, 12'd255);

        // Reset while in REL_MEM clears outputs before the next edge
        step(1'b0);
        for (int j = 0; j < 11; j++) step(1'b1);
        check("in_rel_mem", {9'd0, mem_resetn, cpu_resetn, sys_ready}, 12'h004);
        resetn = 1'b0;
        #1;
        check("async_reset", dut_vec(), 12'h000);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        run_seq("restart", 20, -1, nom_tbl);

        // No lock at all
        apply_reset();
        for (int j = 0; j < 1000; j++) step(1'b0);
`ifdef PLL_LOCK_TIMEOUT_EN
        check("nolock_timeout", {mem_resetn, cpu_resetn, sys_ready, lock_timeout, 8'd0}, 12'hF00);
        for (int j = 0; j < 40; j++) step(1'(j % 3 == 0));
        check("timeout_ignores_lock", dut_vec(), 12'hF00);
`else
        check("nolock_idle", dut_vec(), 12'h000);
`endif

        // Randomized lock behaviour against the model
        apply_reset();
        for (int r = 0; r < 250; r++) begin
            bit lv;
            int len;
            lv  = ($urandom_range(0, 3) != 0);
            len = lv ? $urandom_range(1, 30) : $urandom_range(1, 4);
            for (int j = 0; j < len; j++) step(lv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
